// File: rtl/store_buffer.sv
// Posted-write FIFO that queues word/half/byte stores and drains them to a
// byte-serial memory bus little-endian, with word-granular load-conflict reporting.
module store_buffer #(
  parameter int DEPTH_LOG  = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  wr_i,
  input  logic [2:0]            len_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           data_i,
  output logic                  busy_o,
  output logic                  empty_o,
  output logic                  mem_req,
  input  logic                  mem_grant,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_dout,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_conflict
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] CNT_ONE   = (DEPTH_LOG+1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // Length is kept as the index of the final byte so the drain compares k directly.
  function automatic logic [1:0] last_idx(input logic [2:0] len);
    case (len)
      3'd1:    return 2'd0;
      3'd2:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic same_word(input logic [ADDR_WIDTH-1:0] a,
                                     input logic [ADDR_WIDTH-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

  logic [ADDR_WIDTH-1:0] ent_addr_q [DEPTH];
  logic [1:0]            ent_last_q [DEPTH];
  logic [31:0]           ent_data_q [DEPTH];

  logic [1:0]           state_q, state_d;
  logic [1:0]           k_q, k_d;
  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;

  logic                 full, push, pop;
  logic [DEPTH_LOG-1:0] off;

  always_comb begin
    full = (count_q == DEPTH_CNT);
    push = rdy && wr_i && !full;
    pop  = rdy && (state_q == S_SEND) && mem_grant && (k_q == ent_last_q[head_q]);

    state_d = state_q;
    k_d     = k_q;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;

    if (rdy) begin
      case (state_q)
        S_IDLE: if (count_q != '0) begin
          state_d = S_WAIT;
          k_d     = 2'd0;
        end
        S_WAIT: if (mem_grant) state_d = S_SEND;
        S_SEND: if (mem_grant) begin
          if (pop) state_d = S_IDLE;
          else     k_d     = k_q + 2'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o   = (count_q >= DEPTH_CNT - CNT_ONE);
    empty_o  = (count_q == '0) && (state_q == S_IDLE);
    mem_req  = (state_q == S_WAIT) || (state_q == S_SEND);
    mem_wr   = rdy && (state_q == S_SEND) && mem_grant;
    mem_addr = '0;
    mem_dout = '0;
    if (state_q == S_SEND) begin
      mem_addr = ent_addr_q[head_q] + ADDR_WIDTH'(k_q);
      mem_dout = ent_data_q[head_q][{k_q, 3'b000} +: 8];
    end
  end

  // The head stays visible to loads until its last byte has been popped.
  always_comb begin
    query_conflict = wr_i && same_word(addr_i, query_addr);
    off            = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = DEPTH_LOG'(i) - head_q;
      if (({1'b0, off} < count_q) && same_word(ent_addr_q[i], query_addr))
        query_conflict = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_q[tail_q] <= addr_i;
      ent_last_q[tail_q] <= last_idx(len_i);
      ent_data_q[tail_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && rdy && wr_i && full)
      $error("store_buffer: store to %h dropped, buffer full", addr_i);
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: cycle-accurate vector table plus
// hand-written fill, grant-drop and reset-mid-drain sequences.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst, rdy, wr_i, mem_grant;
  logic [2:0]  len_i;
  logic [31:0] addr_i, data_i, query_addr;
  logic        busy_o, empty_o, mem_req, mem_wr, query_conflict;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] Q = 32'h800;

  store_buffer #(.DEPTH_LOG(2), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .wr_i(wr_i), .len_i(len_i),
    .addr_i(addr_i), .data_i(data_i), .busy_o(busy_o), .empty_o(empty_o),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .query_addr(query_addr),
    .query_conflict(query_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, wr;
    logic [2:0]  len;
    logic [31:0] addr, data;
    logic        grant;
    logic [31:0] qaddr;
    logic        e_req, e_wr, ad;
    logic [31:0] e_addr;
    logic [7:0]  e_dout;
    logic        e_busy, e_empty, e_conf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic w, logic [2:0] l, logic [31:0] a,
                              logic [31:0] d, logic g, logic [31:0] q,
                              logic req, logic mwr, logic ad, logic [31:0] ma,
                              logic [7:0] md, logic bsy, logic emp, logic cf);
    vec_t v;
    v.rdy = r; v.wr = w; v.len = l; v.addr = a; v.data = d; v.grant = g;
    v.qaddr = q; v.e_req = req; v.e_wr = mwr; v.ad = ad; v.e_addr = ma;
    v.e_dout = md; v.e_busy = bsy; v.e_empty = emp; v.e_conf = cf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [2:0] l,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic g, input logic [31:0] q);
    rdy = r; wr_i = w; len_i = l; addr_i = a; data_i = d;
    mem_grant = g; query_addr = q;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " busy_o"},  32'(busy_o),  0);
    chk({tag, " empty_o"}, 32'(empty_o), 1);
    chk({tag, " mem_req"}, 32'(mem_req), 0);
    chk({tag, " mem_wr"},  32'(mem_wr),  0);
    chk({tag, " mem_addr"}, mem_addr,    0);
    chk({tag, " mem_dout"}, 32'(mem_dout), 0);
    chk({tag, " query_conflict"}, 32'(query_conflict), 0);
  endtask

  // Waits (bounded) for each byte strobe and checks address and data.
  task automatic expect_bytes(input string name, input logic [31:0] a,
                              input logic [31:0] d, input int n);
    for (int b = 0; b < n; b++) begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (!mem_wr && waited < 30) begin
        step();
        @(negedge clk);
        waited++;
      end
      chk($sformatf("%s byte%0d mem_wr", name, b), 32'(mem_wr), 1);
      if (mem_wr) begin
        chk($sformatf("%s byte%0d mem_addr", name, b), mem_addr, a + 32'(b));
        chk($sformatf("%s byte%0d mem_dout", name, b), 32'(mem_dout), (d >> (8 * b)) & 32'hFF);
      end
      step();
    end
  endtask

  initial begin
    int stray;

    // Single word store, grant tied high.
    tbl.push_back(mk(1,1,4,'h100,'h11223344,1,Q, 0,0,0,0,0,     0,1,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h100,'h44, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h101,'h33, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h102,'h22, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h103,'h11, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               0,0,0,0,0,     0,1,0));
    // Mixed lengths pushed back to back.
    tbl.push_back(mk(1,1,1,'h200,'h7F,1,Q,        0,0,0,0,0,     0,1,0));
    tbl.push_back(mk(1,1,2,'h202,'hBEEF,1,Q,      0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,1,4,'h204,'hCAFEBABE,1,Q,  1,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h200,'h7F, 1,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h202,'hEF, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h203,'hBE, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               0,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h204,'hBE, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h205,'hBA, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h206,'hFE, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               1,1,1,'h207,'hCA, 0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,Q,               0,0,0,0,0,     0,1,0));
    // Conflict queries, with one rdy=0 freeze cycle mid-drain.
    tbl.push_back(mk(1,1,4,'h300,'h0D0C0B0A,0,'h302, 0,0,0,0,0,  0,1,1));
    tbl.push_back(mk(1,0,4,0,0,0,'h302,           0,0,0,0,0,     0,0,1));
    tbl.push_back(mk(1,0,4,0,0,0,'h304,           1,0,0,0,0,     0,0,0));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           1,0,0,0,0,     0,0,1));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           1,1,1,'h300,'h0A, 0,0,1));
    tbl.push_back(mk(0,0,4,0,0,1,'h302,           1,0,1,'h301,'h0B, 0,0,1));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           1,1,1,'h301,'h0B, 0,0,1));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           1,1,1,'h302,'h0C, 0,0,1));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           1,1,1,'h303,'h0D, 0,0,1));
    tbl.push_back(mk(1,0,4,0,0,1,'h302,           0,0,0,0,0,     0,1,0));

    drive(1,0,4,0,0,0,Q);
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].wr, tbl[i].len, tbl[i].addr, tbl[i].data,
            tbl[i].grant, tbl[i].qaddr);
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d mem_wr", i),  32'(mem_wr),  32'(tbl[i].e_wr));
      if (tbl[i].ad) begin
        chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].e_addr);
        chk($sformatf("row%0d mem_dout", i), 32'(mem_dout), 32'(tbl[i].e_dout));
      end
      chk($sformatf("row%0d busy_o", i),  32'(busy_o),  32'(tbl[i].e_busy));
      chk($sformatf("row%0d empty_o", i), 32'(empty_o), 32'(tbl[i].e_empty));
      chk($sformatf("row%0d query_conflict", i), 32'(query_conflict), 32'(tbl[i].e_conf));
      step();
    end

    // Fill all four entries with the grant held low.
    for (int i = 0; i < 4; i++) begin
      drive(1,1,4, 32'h400 + 32'(4*i), 32'h10203040 + 32'(i) * 32'h01010101, 0, Q);
      @(negedge clk);
      chk($sformatf("fill%0d busy_o", i), 32'(busy_o), (i == 3) ? 1 : 0);
      step();
    end
    drive(1,0,4,0,0,0,Q);
    @(negedge clk);
    chk("fill full busy_o", 32'(busy_o), 1);
    chk("fill full empty_o", 32'(empty_o), 0);
    chk("fill full mem_req", 32'(mem_req), 1);
    step();
    drive(1,0,4,0,0,1,Q);
    for (int i = 0; i < 4; i++)
      expect_bytes($sformatf("drain%0d", i), 32'h400 + 32'(4*i),
                   32'h10203040 + 32'(i) * 32'h01010101, 4);
    @(negedge clk);
    chk("drain done empty_o", 32'(empty_o), 1);
    step();

    // Grant drops for two cycles after the first byte.
    drive(1,1,4,'h500,'h55667788,1,Q);
    step();
    drive(1,0,4,0,0,1,Q);
    expect_bytes("gd_first", 'h500, 'h55667788, 1);
    drive(1,0,4,0,0,0,Q);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("gap%0d mem_wr", i), 32'(mem_wr), 0);
      chk($sformatf("gap%0d mem_req", i), 32'(mem_req), 1);
      step();
    end
    drive(1,0,4,0,0,1,Q);
    expect_bytes("gd_rest", 'h501, 'h00556677, 3);
    @(negedge clk);
    chk("gd done empty_o", 32'(empty_o), 1);
    step();

    // Reset after the second byte of a word store.
    drive(1,1,4,'h600,'h99AABBCC,1,Q);
    step();
    drive(1,0,4,0,0,1,Q);
    expect_bytes("rs", 'h600, 'h99AABBCC, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid reset");
    step();
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_wr || mem_req) stray++;
      step();
    end
    chk("activity after reset", 32'(stray), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
